// File: rtl/mem_addr_pkg.sv
// Shared select encodings and FSM state type for the memory-address unit.
package mem_addr_pkg;

  localparam logic [2:0] SEL_PC    = 3'd0;
  localparam logic [2:0] SEL_S     = 3'd1;
  localparam logic [2:0] SEL_SAIDA = 3'd2;
  localparam logic [2:0] SEL_VEC0  = 3'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_addr_watchdog.sv
// Access watchdog: counts unacknowledged ACCESS cycles and flags the one
// that exhausts the TIMEOUT budget. Only instantiated with MEM_ADDR_TIMEOUT_EN.
module mem_addr_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Expiry is combinational so the abort lands on the same edge as the last
  // unacknowledged cycle.
  always_comb begin
    expired_c = enable && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Counter clears on entry to ACCESS and steps on each unacknowledged cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired_c) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_addr_unit.sv
// Registered memory-address selector and request/ready access sequencer.
// Optional watchdog abort enabled by defining MEM_ADDR_TIMEOUT_EN.
module mem_addr_unit
  import mem_addr_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        NUM_VEC  = 3,
  parameter logic [ADDR_W-1:0]  VEC_BASE = ADDR_W'(253),
  parameter int unsigned        TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_out,
  input  logic [ADDR_W-1:0] alu_s,
  input  logic [ADDR_W-1:0] alu_saida,
  input  logic [2:0]        sel,
  input  logic              req,
  input  logic              we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Reject parameter values outside the supported range at elaboration.
  if (NUM_VEC == 0 || NUM_VEC > 5 || TIMEOUT == 0) begin : g_param_check
    $error("mem_addr_unit: NUM_VEC must be 1..5 and TIMEOUT at least 1");
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic                sel_legal_c;
  logic [2:0]          vec_idx_c;
  logic [ADDR_W-1:0]   addr_d;
  logic                we_d;
  logic                req_d;
  logic                done_d;
  logic                err_d;

`ifdef MEM_ADDR_TIMEOUT_EN
  logic wd_clear_c;
  logic wd_en_c;
  logic wd_expired_c;

  mem_addr_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (wd_clear_c),
    .enable    (wd_en_c),
    .expired_c (wd_expired_c)
  );
`endif

  // Address source mux; vector entries wrap at ADDR_W.
  always_comb begin
    vec_idx_c   = sel - SEL_VEC0;
    sel_legal_c = ({1'b0, sel} < (4'(SEL_VEC0) + 4'(NUM_VEC)));
    case (sel)
      SEL_PC:    sel_addr_c = pc_out;
      SEL_S:     sel_addr_c = alu_s;
      SEL_SAIDA: sel_addr_c = alu_saida;
      default:   sel_addr_c = VEC_BASE + ADDR_W'(vec_idx_c);
    endcase
  end

  // Next-state and next-output logic; address and we only move on acceptance.
  always_comb begin
    state_d = state_q;
    addr_d  = mem_addr;
    we_d    = mem_we;
    req_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef MEM_ADDR_TIMEOUT_EN
    wd_clear_c = 1'b0;
    wd_en_c    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          if (sel_legal_c) begin
            addr_d  = sel_addr_c;
            we_d    = we;
            req_d   = 1'b1;
            state_d = ACCESS;
`ifdef MEM_ADDR_TIMEOUT_EN
            wd_clear_c = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        req_d = 1'b1;
        if (mem_ready) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
`ifdef MEM_ADDR_TIMEOUT_EN
          wd_en_c = 1'b1;
          if (wd_expired_c) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_req  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_addr <= addr_d;
      mem_we   <= we_d;
      mem_req  <= req_d;
      busy     <= req_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule
